// File: rtl/arith_lut_sched.sv
// arith_lut_sched
// ----------------
// Sequences one AV1 symbol range update. For each accepted symbol it fetches
// the two EC_MIN_PROB correction terms from a shared combinational u-term LUT
// (through a req/gnt handshake), then computes u, v, the new range and the
// increment to add to low.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   symbol request handshake (in_ready only in IDLE)
//   in_rng, in_fl, in_fh  current range and inverse-CDF bounds (Q15, top=32768)
//   in_s, in_n            symbol index and last-symbol index N
//   lut_req / lut_gnt     LUT access handshake; lut_q valid in the grant cycle
//   lut_addr, lut_q       LUT address {N, idx} and returned term
//   out_valid / out_ready result handshake; results held until accepted
//   out_rng, out_low_add  new range and low increment
//   out_err               request had s > N
//   stall_cnt             LUT grant-stall counter
//
// Build option: define ARITH_LUT_SCHED_STATS_EN to build the saturating
// grant-stall counter; otherwise stall_cnt is tied to zero.
module arith_lut_sched #(
    parameter int RANGE_WIDTH    = 16,
    parameter int CDF_WIDTH      = 16,
    parameter int SYM_WIDTH      = 4,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int LUT_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [RANGE_WIDTH-1:0]    in_rng,
    input  logic [CDF_WIDTH-1:0]      in_fl,
    input  logic [CDF_WIDTH-1:0]      in_fh,
    input  logic [SYM_WIDTH-1:0]      in_s,
    input  logic [SYM_WIDTH-1:0]      in_n,
    output logic                      lut_req,
    input  logic                      lut_gnt,
    output logic [LUT_ADDR_WIDTH-1:0] lut_addr,
    input  logic [LUT_DATA_WIDTH-1:0] lut_q,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RANGE_WIDTH-1:0]    out_rng,
    output logic [RANGE_WIDTH-1:0]    out_low_add,
    output logic                      out_err,
    output logic [15:0]               stall_cnt
);

    typedef enum logic [2:0] {IDLE, LOOK_U, LOOK_V, CALC, DONE} state_t;

    // fl equal to the CDF top (32768 for Q15) marks the first symbol: no u.
    localparam logic [CDF_WIDTH-1:0] CDF_TOP = {1'b1, {(CDF_WIDTH-1){1'b0}}};

    state_t                    state_q, state_d;
    logic [RANGE_WIDTH-1:0]    rng_q, rng_d;
    logic [CDF_WIDTH-1:0]      fl_q, fl_d, fh_q, fh_d;
    logic [SYM_WIDTH-1:0]      s_q, s_d, n_q, n_d;
    logic [LUT_DATA_WIDTH-1:0] u_term_q, u_term_d, v_term_q, v_term_d;
    logic                      lut_req_q, lut_req_d;
    logic [LUT_ADDR_WIDTH-1:0] lut_addr_q, lut_addr_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic [RANGE_WIDTH-1:0]    out_rng_q, out_rng_d, out_low_add_q, out_low_add_d;
    logic                      out_err_q, out_err_d;
    logic [31:0]               u_s, v_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d       = state_q;
        rng_d         = rng_q;
        fl_d          = fl_q;
        fh_d          = fh_q;
        s_d           = s_q;
        n_d           = n_q;
        u_term_d      = u_term_q;
        v_term_d      = v_term_q;
        out_rng_d     = out_rng_q;
        out_low_add_d = out_low_add_q;
        out_err_d     = out_err_q;
        lut_req_d     = 1'b0;
        lut_addr_d    = '0;

        // The 8x10 products fit comfortably; 32 bits keeps the sums exact.
        u_s = ((32'(rng_q >> 8) * 32'(fl_q >> 6)) >> 1) + 32'(u_term_q);
        v_s = ((32'(rng_q >> 8) * 32'(fh_q >> 6)) >> 1) + 32'(v_term_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rng_d   = in_rng;
                    fl_d    = in_fl;
                    fh_d    = in_fh;
                    s_d     = in_s;
                    n_d     = in_n;
                    state_d = LOOK_U;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOK_U: begin
                if ((fl_q < CDF_TOP) && (s_q <= n_q)) begin
                    if (lut_gnt) begin
                        u_term_d = lut_q;
                        state_d  = LOOK_V;
                    end else begin
                        state_d  = LOOK_U;
                    end
                end else begin
                    u_term_d = '0;
                    state_d  = LOOK_V;
                end
            end
            LOOK_V: begin
                if (s_q < n_q) begin
                    if (lut_gnt) begin
                        v_term_d = lut_q;
                        state_d  = CALC;
                    end else begin
                        state_d  = LOOK_V;
                    end
                end else begin
                    v_term_d = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (s_q > n_q) begin
                    out_err_d     = 1'b1;
                    out_rng_d     = rng_q;
                    out_low_add_d = '0;
                end else if (fl_q < CDF_TOP) begin
                    out_err_d     = 1'b0;
                    out_low_add_d = RANGE_WIDTH'(32'(rng_q) - u_s);
                    out_rng_d     = RANGE_WIDTH'(u_s - v_s);
                end else begin
                    out_err_d     = 1'b0;
                    out_low_add_d = '0;
                    out_rng_d     = RANGE_WIDTH'(32'(rng_q) - v_s);
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Request/address are decoded from the next state so they leave a flop;
        // a stalled lookup naturally re-decodes to the same request.
        if ((state_d == LOOK_U) && (fl_d < CDF_TOP) && (s_d <= n_d)) begin
            lut_req_d  = 1'b1;
            lut_addr_d = LUT_ADDR_WIDTH'({n_d, s_d});
        end else if ((state_d == LOOK_V) && (s_d < n_d)) begin
            // s < N here, so s+1 cannot wrap the index field.
            lut_req_d  = 1'b1;
            lut_addr_d = LUT_ADDR_WIDTH'({n_d, SYM_WIDTH'(s_d + SYM_WIDTH'(1))});
        end else begin
            lut_req_d  = 1'b0;
            lut_addr_d = '0;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rng_q         <= '0;
            fl_q          <= '0;
            fh_q          <= '0;
            s_q           <= '0;
            n_q           <= '0;
            u_term_q      <= '0;
            v_term_q      <= '0;
            lut_req_q     <= 1'b0;
            lut_addr_q    <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_rng_q     <= '0;
            out_low_add_q <= '0;
            out_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rng_q         <= rng_d;
            fl_q          <= fl_d;
            fh_q          <= fh_d;
            s_q           <= s_d;
            n_q           <= n_d;
            u_term_q      <= u_term_d;
            v_term_q      <= v_term_d;
            lut_req_q     <= lut_req_d;
            lut_addr_q    <= lut_addr_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_rng_q     <= out_rng_d;
            out_low_add_q <= out_low_add_d;
            out_err_q     <= out_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign lut_req     = lut_req_q;
    assign lut_addr    = lut_addr_q;
    assign out_valid   = out_valid_q;
    assign out_rng     = out_rng_q;
    assign out_low_add = out_low_add_q;
    assign out_err     = out_err_q;

`ifdef ARITH_LUT_SCHED_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where the LUT request waited for a grant.
    always_comb begin
        if (lut_req_q && !lut_gnt && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_arith_lut_sched.sv
// Self-checking bench for arith_lut_sched: directed cases plus randomized
// symbols compared against an arithmetic reference model of the range update.
module tb_arith_lut_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [15:0] in_rng, in_fl, in_fh;
    logic [3:0]  in_s, in_n;
    logic        lut_req, lut_gnt;
    logic [7:0]  lut_addr;
    logic [15:0] lut_q;
    logic        out_valid, out_ready;
    logic [15:0] out_rng, out_low_add;
    logic        out_err;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // LUT and grant environment
    int          stall_budget = 0;
    bit          gnt_rand = 1'b0;
    bit          gnt_low_en = 1'b0;
    logic [7:0]  gnt_low_addr = 8'h00;
    logic [7:0]  addr_q[$];
    int          txn_stalls = 0;
    int          total_stalls = 0;
    int          addr_viol = 0;

    arith_lut_sched dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rng(in_rng), .in_fl(in_fl), .in_fh(in_fh), .in_s(in_s), .in_n(in_n),
        .lut_req(lut_req), .lut_gnt(lut_gnt), .lut_addr(lut_addr), .lut_q(lut_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rng(out_rng), .out_low_add(out_low_add), .out_err(out_err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lut_model(input logic [7:0] a);
        int n, idx;
        n   = int'(a[7:4]);
        idx = int'(a[3:0]);
        if (idx <= n) return 16'(4 * (n - idx + 1));
        else          return 16'hDEAD;
    endfunction

    assign lut_q = lut_model(lut_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Grant driver: directed stalls, a per-address hold-off, or random grants.
    initial begin
        lut_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (lut_req && stall_budget > 0) begin
                lut_gnt = 1'b0;
                stall_budget--;
            end else if (lut_req && gnt_low_en && lut_addr == gnt_low_addr) begin
                lut_gnt = 1'b0;
            end else if (gnt_rand) begin
                lut_gnt = ($urandom_range(0, 3) != 0);
            end else begin
                lut_gnt = 1'b1;
            end
        end
    end

    // LUT bus monitor, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (lut_req && lut_gnt) addr_q.push_back(lut_addr);
            if (lut_req && !lut_gnt) begin
                txn_stalls++;
                total_stalls++;
            end
            if (!lut_req && lut_addr != 8'h00) addr_viol++;
        end
    end

    function automatic logic [15:0] exp_stats();
`ifdef ARITH_LUT_SCHED_STATS_EN
        return (total_stalls > 65535) ? 16'hFFFF : 16'(total_stalls);
`else
        return 16'd0;
`endif
    endfunction

    // One symbol end to end; entered and left just after a rising edge.
    task automatic run_sym(input string tag, input logic [15:0] r, input logic [15:0] fl,
                           input logic [15:0] fh, input logic [3:0] s, input logic [3:0] n,
                           input int rdy_delay);
        logic [7:0] exp_addr[$];
        int  u, v, e_rng, e_low, guard, edges;
        bit  e_err, first;
        first = (fl >= 16'd32768);
        e_err = (s > n);
        if (!e_err && !first) exp_addr.push_back({n, s});
        if (s < n)            exp_addr.push_back({n, 4'(s + 4'd1)});
        u = ((int'(r) / 256) * (int'(fl) / 64)) / 2 + ((!e_err && !first) ? 4 * (int'(n) - int'(s) + 1) : 0);
        v = ((int'(r) / 256) * (int'(fh) / 64)) / 2 + ((s < n) ? 4 * (int'(n) - int'(s)) : 0);
        if (e_err) begin
            e_rng = int'(r); e_low = 0;
        end else if (!first) begin
            e_rng = u - v; e_low = int'(r) - u;
        end else begin
            e_rng = int'(r) - v; e_low = 0;
        end
        e_rng = e_rng & 32'hFFFF;
        e_low = e_low & 32'hFFFF;

        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check_eq({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        addr_q.delete();
        txn_stalls = 0;
        in_valid = 1'b1; in_rng = r; in_fl = fl; in_fh = fh; in_s = s; in_n = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_rng = 16'($urandom); in_fl = 16'($urandom); in_fh = 16'($urandom);
        in_s = 4'($urandom); in_n = 4'($urandom);

        edges = 0;
        @(negedge clk);
        while (!out_valid && edges < 300) begin
            edges++;
            @(negedge clk);
        end
        check_eq({tag, ".latency"}, 32'(edges), 32'(3 + txn_stalls));
        check_eq({tag, ".rng"}, 32'(out_rng), 32'(e_rng));
        check_eq({tag, ".low_add"}, 32'(out_low_add), 32'(e_low));
        check_eq({tag, ".err"}, 32'(out_err), 32'(e_err));
        check_eq({tag, ".n_lookups"}, 32'(addr_q.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++)
            check_eq($sformatf("%s.addr%0d", tag, i), 32'(addr_q[i]), 32'(exp_addr[i]));

        out_ready = (rdy_delay == 0);
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s.hold%0d.valid", tag, k), 32'(out_valid), 32'd1);
            check_eq($sformatf("%s.hold%0d.rng", tag, k), 32'(out_rng), 32'(e_rng));
            check_eq($sformatf("%s.hold%0d.low", tag, k), 32'(out_low_add), 32'(e_low));
            check_eq($sformatf("%s.hold%0d.err", tag, k), 32'(out_err), 32'(e_err));
            check_eq($sformatf("%s.hold%0d.in_ready", tag, k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] r, fl, fh;
        logic [3:0]  s, n;
        int          guard;
        bit          seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_rng = 16'd0; in_fl = 16'd0; in_fh = 16'd0; in_s = 4'd0; in_n = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst.in_ready", 32'(in_ready), 32'd1);
        check_eq("rst.lut_req", 32'(lut_req), 32'd0);
        check_eq("rst.lut_addr", 32'(lut_addr), 32'd0);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.out_rng", 32'(out_rng), 32'd0);
        check_eq("rst.out_low_add", 32'(out_low_add), 32'd0);
        check_eq("rst.out_err", 32'(out_err), 32'd0);
        check_eq("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
        total_stalls = 0;

        run_sym("c1", 16'h8000, 16'd16384, 16'd8192, 4'd1, 4'd3, 0);
        run_sym("c2", 16'd40000, 16'd32768, 16'd20000, 4'd0, 4'd2, 0);
        run_sym("c3", 16'h8000, 16'd4096, 16'd0, 4'd3, 4'd3, 1);
        stall_budget = 3;
        run_sym("c4", 16'h8000, 16'd16384, 16'd8192, 4'd1, 4'd3, 0);
        check_eq("c4.stall_cnt", 32'(stall_cnt), 32'(exp_stats()));
        run_sym("c5", 16'd50000, 16'd20000, 16'd10000, 4'd5, 4'd3, 4);

        // Reset while the v lookup is stalled.
        gnt_low_addr = 8'h32; gnt_low_en = 1'b1;
        in_valid = 1'b1; in_rng = 16'h8000; in_fl = 16'd16384; in_fh = 16'd8192;
        in_s = 4'd1; in_n = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0; guard = 0;
        while (!seen && guard < 20) begin
            @(negedge clk);
            seen = lut_req && (lut_addr == 8'h32) && !lut_gnt;
            guard++;
        end
        check_eq("rst_mid.stall_seen", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; gnt_low_en = 1'b0; total_stalls = 0;
        check_eq("rst_mid.lut_req", 32'(lut_req), 32'd0);
        check_eq("rst_mid.lut_addr", 32'(lut_addr), 32'd0);
        check_eq("rst_mid.in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_mid.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid.stall_cnt", 32'(stall_cnt), 32'd0);
        run_sym("c6", 16'h8000, 16'd16384, 16'd8192, 4'd1, 4'd3, 0);

        // Randomized symbols with random grant stalls and backpressure.
        gnt_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n  = 4'($urandom_range(0, 15));
            s  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, int'(n)));
            r  = 16'($urandom_range(32768, 65535));
            fh = 16'($urandom_range(0, 32767));
            fl = ($urandom_range(0, 4) == 0) ? 16'd32768 : 16'($urandom_range(int'(fh), 32767));
            run_sym($sformatf("rnd%0d", i), r, fl, fh, s, n, $urandom_range(0, 3));
        end
        gnt_rand = 1'b0;
        check_eq("rnd.stall_cnt", 32'(stall_cnt), 32'(exp_stats()));
        check_eq("addr_zero_without_req", 32'(addr_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_lut_sched.md
Name: arith_lut_sched

Overview:
- Sequences one AV1 symbol range update. Per symbol it fetches the two EC_MIN_PROB correction terms from the shared u-term LUT, then computes u, v, the new range and the low increment.
- The LUT is a single combinational instance shared with other users, so the block requests it through a req/gnt pair.
- Sits between the symbol/CDF front end and the renormalization stage of the arithmetic encoder.

Parameters:
RANGE_WIDTH, 16, width of range input/output and low increment
CDF_WIDTH, 16, width of fl/fh (Q15 inverse CDF values, top = 32768)
SYM_WIDTH, 4, width of symbol index s and last-symbol index N
LUT_ADDR_WIDTH, 8, LUT address width; address = {N, index}
LUT_DATA_WIDTH, 16, LUT data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  symbol request valid
in_ready  out  1  block can accept a request
in_rng  in  RANGE_WIDTH  current range r
in_fl  in  CDF_WIDTH  inverse CDF low bound
in_fh  in  CDF_WIDTH  inverse CDF high bound
in_s  in  SYM_WIDTH  symbol index s
in_n  in  SYM_WIDTH  last symbol index N (nsyms-1)
lut_req  out  1  LUT access request
lut_gnt  in  1  LUT grant; lut_q is valid in the same cycle
lut_addr  out  LUT_ADDR_WIDTH  LUT address
lut_q  in  LUT_DATA_WIDTH  LUT data, equal to 4*(N-idx+1) for idx<=N
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_rng  out  RANGE_WIDTH  new range
out_low_add  out  RANGE_WIDTH  amount to add to low
out_err  out  1  s>N request flagged
stall_cnt  out  16  LUT grant-stall count (optional feature)

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, lut_req=0, lut_addr=0, out_valid=0, out_rng=0, out_low_add=0, out_err=0, stall_cnt=0.
- FSM states: IDLE, LOOK_U, LOOK_V, CALC, DONE. in_ready=1 only in IDLE.
- IDLE: when in_valid is high, register all inputs and go to LOOK_U.
- LOOK_U:
  - If fl<32768 and s<=N: lut_req=1, lut_addr={N,s}. Capture u_term=lut_q on the edge where lut_gnt=1, then go to LOOK_V. Hold state, lut_req and lut_addr while lut_gnt=0.
  - Else: u_term=0, lut_req=0, advance after one cycle.
- LOOK_V:
  - If s<N: lut_req=1, lut_addr={N,s+1}; capture v_term on grant, stall rules as in LOOK_U.
  - If s>=N: v_term=0, lut_req=0, one cycle. The {N,s+1} lookup is never issued when s=N, which prevents the 4-bit index wrap.
- CALC, one cycle. Multiplies are 8x10 bits, the products are 17 bits after the shift, and u and v fit in 17 bits:
  - u = (((r>>8)*(fl>>6))>>1) + u_term
  - v = (((r>>8)*(fh>>6))>>1) + v_term
  - If s>N: out_err=1, out_rng=r, out_low_add=0; both lookups skipped.
  - Else if fl<32768: out_low_add=r-u, out_rng=u-v.
  - Else: out_low_add=0, out_rng=r-v.
  - All results are registered; go to DONE.
- DONE: out_valid=1. Outputs are held stable until out_ready=1, then return to IDLE; out_valid drops the next cycle.
- Latency with lut_gnt tied high: accept edge T, out_valid high in cycle T+4. This holds regardless of skipped lookups. Each grant-stall cycle adds one cycle.
- Throughput: one symbol per 5 cycles minimum.
- lut_req is never asserted outside LOOK_U/LOOK_V. lut_addr=0 whenever lut_req=0.
- lut_gnt while lut_req=0 is ignored.
- Reset in any state, including mid-stall or DONE, drops the request and discards the result. All outputs return to reset values on the next cycle.
- Requests with the same r, fl, fh, s and N always give identical results; no internal history is carried.

Optional Feature:
- Macro ARITH_LUT_SCHED_STATS_EN.
- Defined: stall_cnt increments on every cycle with lut_req=1 and lut_gnt=0. It saturates at 0xFFFF and is cleared only by reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is built. Functional outputs are identical in both builds.

Test Plan:
- gnt=1; r=0x8000, fl=16384, fh=8192, s=1, N=3 -> lut_addr 0x31 then 0x32; out_rng=8196, out_low_add=16372, out_valid at T+4.
- fl=32768, r=40000, fh=20000, s=0, N=2 -> one lookup at addr 0x21 only; out_rng=15656, out_low_add=0.
- s=N=3, r=0x8000, fl=4096, fh=0 -> only addr 0x33 looked up, no req in LOOK_V; out_rng=4100, out_low_add=28668.
- Case 1 with lut_gnt low for 3 cycles in LOOK_U -> addr 0x31 held, out_valid at T+7; stall_cnt=3 with macro, 0 without.
- s=5, N=3 -> no lut_req; out_err=1, out_rng=r, out_low_add=0. Hold out_ready=0 for 4 cycles -> outputs stable and in_ready=0 throughout.
- Assert reset during LOOK_V stall -> next cycle lut_req=0, IDLE, in_ready=1, out_valid=0. The following request computes correctly.
